// File: rtl/memory_subsystem.sv
// memory_subsystem: on-chip memory for the accelerator.
//   Four-bank weight memory (weight_mem) at 0x0000-0x0FFF, a DMA control
//   register at 0xFF00 (R/W), and a DMA status word at 0xFF04 (RO, bit0 echoes
//   dma_control[0]). One shared address/data port, 1-cycle registered read.
//   A fixed-priority arbiter (lowest index wins) registers a one-hot grant.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   addr           : word address
//   data_in        : write data
//   write_enable   : write strobe (read when low)
//   rd_data        : registered read data
//   bank_request   : per-bank access request
//   bank_grant     : registered one-hot (or zero) grant

// One weight bank: synchronous write, combinational read of the array.
module mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on the array: contents survive reset by design.
  always_ff @(posedge clk)
    if (we) mem[word] <= wdata;

  assign rdata = mem[word];
endmodule

// Bank array: one mem_bank per bank, write steered by the bank select.
module weight_bank_array #(
  parameter int DATA_WIDTH = 32,
  parameter int BANK_DEPTH = 1024,
  parameter int NUM_BANKS  = 4,
  parameter int WORD_W     = $clog2(BANK_DEPTH),
  parameter int BANK_W     = $clog2(NUM_BANKS)
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [BANK_W-1:0]                     bank_sel,
  input  logic [WORD_W-1:0]                     word,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  rd_words
);
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(BANK_DEPTH)) u_bank (
      .clk   (clk),
      .we    (we && (bank_sel == BANK_W'(b))),
      .word  (word),
      .wdata (wdata),
      .rdata (rd_words[b])
    );
  end
endmodule

module memory_subsystem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int BANK_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [3:0]            bank_request,
  output logic [3:0]            bank_grant
);
  localparam int NUM_BANKS = 4;
  localparam int WORD_W    = $clog2(BANK_DEPTH);
  localparam int BANK_W    = 2;
  localparam logic [ADDR_WIDTH-1:0] WEIGHT_LIMIT  = ADDR_WIDTH'(NUM_BANKS * BANK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DMA_CTRL_ADDR = ADDR_WIDTH'(16'hFF00);
  localparam logic [ADDR_WIDTH-1:0] DMA_STAT_ADDR = ADDR_WIDTH'(16'hFF04);

  logic                                 is_weight, is_ctrl, is_stat;
  logic [BANK_W-1:0]                    bank_sel;
  logic [WORD_W-1:0]                    word;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rd_words;
  logic [DATA_WIDTH-1:0]                dma_control;
  logic [DATA_WIDTH-1:0]                dma_status;
  logic [DATA_WIDTH-1:0]                rd_next;
  logic [3:0]                           winner;

  // Address decode
  assign is_weight = addr < WEIGHT_LIMIT;
  assign is_ctrl   = addr == DMA_CTRL_ADDR;
  assign is_stat   = addr == DMA_STAT_ADDR;
  assign bank_sel  = addr[WORD_W +: BANK_W];
  assign word      = addr[WORD_W-1:0];

  // Reset gates the array write so a write coincident with reset is dropped.
  weight_bank_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .BANK_DEPTH (BANK_DEPTH),
    .NUM_BANKS  (NUM_BANKS)
  ) weight_mem (
    .clk      (clk),
    .we       (write_enable && !reset && is_weight),
    .bank_sel (bank_sel),
    .word     (word),
    .wdata    (data_in),
    .rd_words (rd_words)
  );

  always_ff @(posedge clk)
    if (reset)                        dma_control <= '0;
    else if (write_enable && is_ctrl) dma_control <= data_in;

  assign dma_status = DATA_WIDTH'(dma_control[0]);

  always_comb begin
    rd_next = '0;
    if (is_weight)    rd_next = rd_words[bank_sel];
    else if (is_ctrl) rd_next = dma_control;
    else if (is_stat) rd_next = dma_status;
  end

  // rd_data holds during write cycles.
  always_ff @(posedge clk)
    if (reset)              rd_data <= '0;
    else if (!write_enable) rd_data <= rd_next;

  // Lowest set bit isolates the fixed-priority winner; zero when no request.
  assign winner = bank_request & (~bank_request + 4'd1);

  always_ff @(posedge clk)
    if (reset) bank_grant <= '0;
    else       bank_grant <= winner;
endmodule

// File: tb/tb_memory_subsystem.sv
module tb_memory_subsystem;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] rd_data;
  logic [3:0]  bank_request;
  logic [3:0]  bank_grant;

  memory_subsystem dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .rd_data      (rd_data),
    .bank_request (bank_request),
    .bank_grant   (bank_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        chk_rd;
    logic [31:0] rd;
    logic        chk_g;
    logic [3:0]  g;
    logic        chk_d;
    logic [31:0] d;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total  = 0;
  int    passed = 0;
  bit    done   = 1'b0;

  // Drive one cycle of inputs (at negedge) and queue what the outputs must be
  // after the following rising edge.
  task automatic step(input logic rst, input logic we, input logic [15:0] a,
                      input logic [31:0] din, input logic [3:0] req,
                      input logic crd, input logic [31:0] erd,
                      input logic cg, input logic [3:0] eg,
                      input logic cd, input logic [31:0] ed, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst; write_enable = we; addr = a; data_in = din; bank_request = req;
    e = '{chk_rd: crd, rd: erd, chk_g: cg, g: eg, chk_d: cd, d: ed};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.chk_rd) begin
          total++;
          if (rd_data === e.rd) passed++;
          else $display("FAIL %s rd_data: got %h expected %h", nm, rd_data, e.rd);
        end
        if (e.chk_g) begin
          total++;
          if (bank_grant === e.g) passed++;
          else $display("FAIL %s bank_grant: got %b expected %b", nm, bank_grant, e.g);
        end
        if (e.chk_d) begin
          total++;
          if (dut.dma_control === e.d) passed++;
          else $display("FAIL %s dma_control: got %h expected %h", nm, dut.dma_control, e.d);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; write_enable = 1'b0; addr = '0; data_in = '0; bank_request = '0;
    //   rst we  addr      data          req      crd rd             cg g        cd dma
    step(1, 1, 16'hFF00, 32'hFFFFFFFF, 4'b1111, 1, 32'h0,        1, 4'b0000, 1, 32'h0, "reset1");
    step(1, 1, 16'hFF00, 32'hFFFFFFFF, 4'b1111, 1, 32'h0,        1, 4'b0000, 1, 32'h0, "reset2");
    step(0, 0, 16'hFF00, 32'h0,        4'b0000, 1, 32'h0,        1, 4'b0000, 1, 32'h0, "post_reset");
    step(0, 1, 16'hFF00, 32'hA5A5A5A5, 4'b1010, 1, 32'h0,        1, 4'b0010, 1, 32'hA5A5A5A5, "wr_ctrl");
    step(0, 0, 16'hFF00, 32'h0,        4'b1000, 1, 32'hA5A5A5A5, 1, 4'b1000, 1, 32'hA5A5A5A5, "rd_ctrl");
    step(0, 0, 16'hFF04, 32'h0,        4'b0000, 1, 32'h1,        1, 4'b0000, 0, 32'h0, "rd_stat");
    step(0, 0, 16'hFF04, 32'h0,        4'b1111, 1, 32'h1,        1, 4'b0001, 0, 32'h0, "arb_all");
    step(0, 1, 16'h0000, 32'h11111111, 4'b0110, 1, 32'h1,        1, 4'b0010, 0, 32'h0, "wr_b0");
    step(0, 1, 16'h0400, 32'h22222222, 4'b1100, 1, 32'h1,        1, 4'b0100, 0, 32'h0, "wr_b1");
    step(0, 1, 16'h0800, 32'h33333333, 4'b0000, 1, 32'h1,        1, 4'b0000, 0, 32'h0, "wr_b2");
    step(0, 1, 16'h0FFF, 32'h44444444, 4'b0000, 1, 32'h1,        0, 4'b0000, 0, 32'h0, "wr_b3");
    step(0, 0, 16'h0000, 32'h0,        4'b0000, 1, 32'h11111111, 0, 4'b0000, 0, 32'h0, "rd_b0");
    step(0, 0, 16'h0400, 32'h0,        4'b0000, 1, 32'h22222222, 0, 4'b0000, 0, 32'h0, "rd_b1");
    step(0, 0, 16'h0800, 32'h0,        4'b0000, 1, 32'h33333333, 0, 4'b0000, 0, 32'h0, "rd_b2");
    step(0, 0, 16'h0FFF, 32'h0,        4'b0000, 1, 32'h44444444, 0, 4'b0000, 0, 32'h0, "rd_b3");
    step(0, 1, 16'h0C00, 32'h55555555, 4'b0000, 1, 32'h44444444, 0, 4'b0000, 0, 32'h0, "wr_b3w0");
    step(0, 0, 16'h0C00, 32'h0,        4'b0000, 1, 32'h55555555, 0, 4'b0000, 0, 32'h0, "raw_b3w0");
    step(0, 0, 16'h2000, 32'h0,        4'b0000, 1, 32'h0,        0, 4'b0000, 0, 32'h0, "rd_unmapped");
    step(0, 1, 16'h1000, 32'h99999999, 4'b0000, 1, 32'h0,        0, 4'b0000, 0, 32'h0, "wr_unmapped");
    step(0, 0, 16'h0000, 32'h0,        4'b0000, 1, 32'h11111111, 0, 4'b0000, 0, 32'h0, "no_alias");
    step(0, 0, 16'h1000, 32'h0,        4'b0000, 1, 32'h0,        0, 4'b0000, 0, 32'h0, "rd_1000");
    step(0, 1, 16'hFF04, 32'hDEADBEEF, 4'b0000, 1, 32'h0,        0, 4'b0000, 1, 32'hA5A5A5A5, "wr_stat");
    step(0, 0, 16'hFF04, 32'h0,        4'b0000, 1, 32'h1,        0, 4'b0000, 0, 32'h0, "stat_ro");
    step(0, 0, 16'hFF00, 32'h0,        4'b0000, 1, 32'hA5A5A5A5, 0, 4'b0000, 0, 32'h0, "ctrl_kept");
    step(0, 1, 16'hFF00, 32'h00000002, 4'b0000, 1, 32'hA5A5A5A5, 0, 4'b0000, 1, 32'h2, "wr_ctrl2");
    step(0, 0, 16'hFF04, 32'h0,        4'b0000, 1, 32'h0,        0, 4'b0000, 0, 32'h0, "stat_bit0");
    step(0, 1, 16'h0010, 32'h12345678, 4'b0100, 1, 32'h0,        1, 4'b0100, 0, 32'h0, "wr_0010");
    step(0, 0, 16'h0010, 32'h0,        4'b0100, 1, 32'h12345678, 1, 4'b0100, 0, 32'h0, "rd_0010");
    step(1, 1, 16'h0010, 32'hCAFEBABE, 4'b0100, 1, 32'h0,        1, 4'b0000, 1, 32'h0, "rst_mid_wr");
    step(0, 0, 16'h0010, 32'h0,        4'b0000, 1, 32'h12345678, 1, 4'b0000, 1, 32'h0, "wr_dropped");

    @(negedge clk);
    write_enable = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
